diff_apply: RTL and testbench
=============================

DIFF_APPLY -- requirements
Module: diff_apply

Interface
REQ-001 Parameter WIDTH, default 32, data word width.
REQ-002 Parameter IDXW, default 6, index token width; value WIDTH is the "no difference" sentinel.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  begin a new reconstruction; sampled only in IDLE.
REQ-006 base  input  WIDTH  reference word A, captured on accepted start.
REQ-007 idx_valid  input  1  index token present.
REQ-008 idx  input  IDXW  differing-bit position, lowest first.
REQ-009 idx_last  input  1  marks final token of the sequence.
REQ-010 idx_ready  output  1  block accepts a token this cycle.
REQ-011 out_valid  output  1  result word available.
REQ-012 result  output  WIDTH  reconstructed word B.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 busy  output  1  high in COLLECT or DONE.
REQ-015 flip_cnt  output  IDXW  number of bits flipped in the current sequence.
REQ-016 err  output  1  sticky protocol-error flag for the current sequence.

Function
REQ-017 Block SHALL reconstruct B from A plus the ascending list of positions where A and B differ, i.e. invert the lowest-differing-bit encoding.
REQ-018 FSM SHALL have exactly three states: IDLE, COLLECT, DONE.
REQ-019 IDLE: idx_ready=0, out_valid=0; start=1 at an edge loads acc=base, flip_cnt=0, err=0, clears last-index record, moves to COLLECT.
REQ-020 start outside IDLE SHALL be ignored with no state change.
REQ-021 COLLECT: idx_ready=1; token accepted on an edge with idx_valid=1 and idx_ready=1.
REQ-022 Accepted token with idx<WIDTH and (first token or idx > previous accepted index) SHALL toggle acc[idx], increment flip_cnt, and record idx as previous.
REQ-023 Accepted token with idx<WIDTH and idx <= previous index SHALL leave acc and flip_cnt unchanged and set err.
REQ-024 Accepted token idx==WIDTH with idx_last=1 SHALL terminate without flipping; with idx_last=0 it SHALL set err and flip nothing.
REQ-025 Accepted token idx>WIDTH SHALL set err and flip nothing.
REQ-026 Accepted token with idx_last=1 SHALL move COLLECT to DONE at the same edge, regardless of error.
REQ-027 DONE: out_valid=1, idx_ready=0; result, flip_cnt, err held stable until out_ready=1 at an edge, then return to IDLE.
REQ-028 result SHALL show acc in all states; it is meaningful only while out_valid=1.
REQ-029 Latency: start edge -> idx_ready high next cycle; last-token edge -> out_valid high next cycle; minimum sequence start-to-out_valid is 2 cycles.
REQ-030 idx_valid while idx_ready=0 SHALL have no effect.
REQ-031 flip_cnt SHALL never exceed WIDTH (guaranteed by strict ascent rule).
REQ-032 err SHALL remain set until the next accepted start or reset.

Reset
REQ-033 rst=1 SHALL immediately, independent of clk, force state IDLE, acc=0, result=0, flip_cnt=0, err=0, out_valid=0, idx_ready=0, busy=0.
REQ-034 Reset mid-COLLECT or mid-DONE SHALL discard the sequence; no result is delivered.
REQ-035 After rst deasserts, first start SHALL be honoured on the next rising edge.

Verification
REQ-036 base=0x000000F0, tokens 4,5,6,7(last) -> result=0x00000000, flip_cnt=4, err=0, out_valid one cycle after token 7.
REQ-037 base=0x12345678, single token 32(last) -> result=0x12345678, flip_cnt=0, err=0.
REQ-038 base=0x00000000, tokens 0,31(last) -> result=0x80000001, flip_cnt=2, err=0.
REQ-039 base=0, tokens 5,3(last) -> result=0x00000020, flip_cnt=1, err=1.
REQ-040 DONE with out_ready low 3 cycles plus start pulses -> result/out_valid stable, start ignored; out_ready=1 -> IDLE next cycle, busy=0.
REQ-041 rst pulsed between clock edges during COLLECT after two tokens -> all outputs 0 immediately; new start then behaves per REQ-036.

Source files
------------

// File: rtl/diff_apply.sv
// diff_apply: rebuilds word B from reference word A plus the ascending list of
// bit positions where A and B differ. Each token toggles one bit of the
// accumulator. The value WIDTH is the "no difference" terminator.
module diff_apply #(
  parameter int WIDTH = 32,
  parameter int IDXW  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic             idx_valid,
  input  logic [IDXW-1:0]  idx,
  input  logic             idx_last,
  output logic             idx_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  input  logic             out_ready,
  output logic             busy,
  output logic [IDXW-1:0]  flip_cnt,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  // The sentinel index must be representable in IDXW bits (WIDTH < 2**IDXW).
  localparam logic [IDXW-1:0] SENT = IDXW'(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc;
  logic [IDXW-1:0]  prev_idx;
  logic             have_prev;
  logic             load, tok_acc;
  logic             in_range, ascend, do_flip, set_err;

  // State register; reset drops any sequence that is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    tok_acc   = 1'b0;
    idx_ready = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        idx_ready = 1'b1;
        busy      = 1'b1;
        if (idx_valid) begin
          tok_acc = 1'b1;
          // The final token ends the sequence even when it is malformed.
          if (idx_last) state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Classify the token. A legal flip must be in range and strictly above the
  // previous flip, which also caps flip_cnt at WIDTH. The terminator is legal
  // only when it is the last token. Any other token raises err.
  always_comb begin
    in_range = (idx < SENT);
    ascend   = !have_prev || (idx > prev_idx);
    do_flip  = tok_acc && in_range && ascend;
    set_err  = tok_acc && !do_flip && !((idx == SENT) && idx_last);
  end

  // Accumulator, flip count, ascent tracking and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      flip_cnt  <= '0;
      err       <= 1'b0;
      prev_idx  <= '0;
      have_prev <= 1'b0;
    end else if (load) begin
      acc       <= base;
      flip_cnt  <= '0;
      err       <= 1'b0;
      prev_idx  <= '0;
      have_prev <= 1'b0;
    end else begin
      if (do_flip) begin
        acc       <= acc ^ (WIDTH'(1) << idx);
        flip_cnt  <= flip_cnt + IDXW'(1);
        prev_idx  <= idx;
        have_prev <= 1'b1;
      end
      if (set_err) err <= 1'b1;
    end
  end

  assign result = acc;

endmodule

// File: tb/tb_diff_apply.sv
// Directed self-checking bench for diff_apply using hand-computed vectors.
module tb_diff_apply;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base;
  logic        idx_valid;
  logic [5:0]  idx;
  logic        idx_last;
  logic        idx_ready;
  logic        out_valid;
  logic [31:0] result;
  logic        out_ready;
  logic        busy;
  logic [5:0]  flip_cnt;
  logic        err;

  int n_chk = 0;
  int n_err = 0;

  diff_apply #(.WIDTH(32), .IDXW(6)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base),
    .idx_valid(idx_valid), .idx(idx), .idx_last(idx_last),
    .idx_ready(idx_ready), .out_valid(out_valid), .result(result),
    .out_ready(out_ready), .busy(busy), .flip_cnt(flip_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after rising.
  task automatic begin_seq(input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    base  = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic tok(input logic [5:0] i, input logic l);
    @(negedge clk);
    idx_valid = 1'b1;
    idx       = i;
    idx_last  = l;
    @(posedge clk); #1;
    idx_valid = 1'b0;
    idx_last  = 1'b0;
  endtask

  task automatic drain;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] r, input logic [31:0] c, input logic e);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".result"}, result, r);
    chk({tag, ".cnt"}, 32'(flip_cnt), c);
    chk({tag, ".err"}, 32'(err), 32'(e));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base = '0; idx_valid = 1'b0; idx = '0;
    idx_last = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst.ready", 32'(idx_ready), 32'd0);
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.busy",  32'(busy), 32'd0);
    chk("rst.result", result, 32'd0);
    #10 rst = 1'b0;

    // Basic sequence: clear the four set bits.
    begin_seq(32'h000000F0);
    chk("s1.ready", 32'(idx_ready), 32'd1);
    chk("s1.busy",  32'(busy), 32'd1);
    tok(6'd4, 1'b0); tok(6'd5, 1'b0); tok(6'd6, 1'b0);
    chk("s1.novalid", 32'(out_valid), 32'd0);
    tok(6'd7, 1'b1);
    chk_out("s1", 32'h0, 32'd4, 1'b0);
    drain;
    chk("s1.idle.valid", 32'(out_valid), 32'd0);
    chk("s1.idle.busy",  32'(busy), 32'd0);

    // Token in IDLE is ignored.
    @(negedge clk); idx_valid = 1'b1; idx = 6'd0;
    @(posedge clk); #1; idx_valid = 1'b0;
    chk("idle.tok.result", result, 32'h0);
    chk("idle.tok.cnt", 32'(flip_cnt), 32'd4);

    // Terminator only: B equals A.
    begin_seq(32'h12345678);
    tok(6'd32, 1'b1);
    chk_out("s2", 32'h12345678, 32'd0, 1'b0);
    drain;

    // Extreme bit positions.
    begin_seq(32'h0);
    tok(6'd0, 1'b0); tok(6'd31, 1'b1);
    chk_out("s3", 32'h80000001, 32'd2, 1'b0);
    drain;

    // Descending index raises err, no flip.
    begin_seq(32'h0);
    tok(6'd5, 1'b0); tok(6'd3, 1'b1);
    chk_out("s4", 32'h00000020, 32'd1, 1'b1);
    drain;
    chk("s4.err.sticky", 32'(err), 32'd1);

    // Non-final terminator is an error; following token still flips.
    begin_seq(32'h0);
    chk("s5.err.clr", 32'(err), 32'd0);
    tok(6'd32, 1'b0); tok(6'd1, 1'b1);
    chk_out("s5", 32'h00000002, 32'd1, 1'b1);
    drain;

    // Out-of-range last token; DONE held with start pulses ignored.
    begin_seq(32'hA5A5A5A5);
    tok(6'd0, 1'b0); tok(6'd33, 1'b1);
    chk_out("s6", 32'hA5A5A5A4, 32'd1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); start = 1'b1; base = 32'hFFFFFFFF;
      @(posedge clk); #1; start = 1'b0;
      chk("hold.valid", 32'(out_valid), 32'd1);
      chk("hold.result", result, 32'hA5A5A5A4);
      chk("hold.cnt", 32'(flip_cnt), 32'd1);
    end
    drain;
    chk("s6.idle.busy",  32'(busy), 32'd0);
    chk("s6.idle.valid", 32'(out_valid), 32'd0);

    // Async reset mid-COLLECT, applied between edges.
    begin_seq(32'h000000FF);
    tok(6'd0, 1'b0); tok(6'd1, 1'b0);
    chk("pre.rst.result", result, 32'h000000FC);
    @(negedge clk); #1;
    rst = 1'b1; #1;
    chk("arst.result", result, 32'h0);
    chk("arst.ready", 32'(idx_ready), 32'd0);
    chk("arst.busy",  32'(busy), 32'd0);
    chk("arst.cnt",   32'(flip_cnt), 32'd0);
    chk("arst.valid", 32'(out_valid), 32'd0);
    #1 rst = 1'b0;

    begin_seq(32'h000000F0);
    chk("s7.ready", 32'(idx_ready), 32'd1);
    tok(6'd4, 1'b0); tok(6'd5, 1'b0); tok(6'd6, 1'b0); tok(6'd7, 1'b1);
    chk_out("s7", 32'h0, 32'd4, 1'b0);
    drain;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
